exec_trace_monitor: RTL and testbench

EXEC_TRACE_MONITOR -- requirements
Module: exec_trace_monitor

---
 rtl/exec_trace_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_exec_trace_monitor.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_trace_monitor.sv
// ---------------------------------------------------------------------------
// exec_trace_monitor
//
// Purpose: records every retiring instruction into a DEPTH-entry trace FIFO
// as {pc, instr, alu_result, mismatch}. An optional result checker
// re-computes the expected ALU result from the decoded opcode and operands
// and flags disagreements. The checker is compiled only when the macro
// EXEC_TRACE_CHECK_EN is defined. Without it, the mismatch bit is 0 and
// err_cnt/first_err_pc/err are tied to 0.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   clear               synchronous soft clear of buffer, counters, flags
//   retire              one instruction retires this cycle
//   pc, instr           PC and instruction word of the retiring instruction
//   rd1, rd2            register-file read operands
//   alu_result          ALU output of the retiring instruction
//   rd_en               pop request for the oldest trace entry
//   rd_valid, rd_data   popped entry, valid one cycle after rd_en
//   count, empty, full  buffer occupancy and status
//   overflow            sticky: a retire arrived while the buffer was full
//   retire_cnt          saturating count of retired instructions
//   err_cnt, err        saturating mismatch count and sticky error flag
//   first_err_pc        PC of the first mismatching instruction
// ---------------------------------------------------------------------------
module exec_trace_monitor #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 1,
  parameter int CNT_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         retire,
  input  logic [PC_W-1:0]              pc,
  input  logic [31:0]                  instr,
  input  logic [DATA_W-1:0]            rd1,
  input  logic [DATA_W-1:0]            rd2,
  input  logic [DATA_W-1:0]            alu_result,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [PC_W+32+DATA_W:0]      rd_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty,
  output logic                         full,
  output logic                         overflow,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic [PC_W-1:0]              first_err_pc,
  output logic                         err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = PC_W + 32 + DATA_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic w_mismatch;

`ifdef EXEC_TRACE_CHECK_EN
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic signed [DATA_W-1:0] w_op_a;
  logic signed [DATA_W-1:0] w_op_b;
  logic signed [DATA_W-1:0] w_exp;
  logic                     w_chk;

  // CBZ, B, NOP and unknown encodings fall to the default arm and never
  // report a mismatch.
  always_comb begin
    w_op_a = rd1;
    w_op_b = rd2;
    w_exp  = '0;
    w_chk  = 1'b0;
    case (instr[31:21])
      OP_ADD:  begin w_exp = w_op_a + w_op_b; w_chk = 1'b1; end
      OP_SUB:  begin w_exp = w_op_a - w_op_b; w_chk = 1'b1; end
      OP_AND:  begin w_exp = w_op_a & w_op_b; w_chk = 1'b1; end
      OP_ORR:  begin w_exp = w_op_a | w_op_b; w_chk = 1'b1; end
      OP_LDUR, OP_STUR: begin
        w_exp = w_op_a + $signed({{(DATA_W-9){1'b0}}, instr[20:12]});
        w_chk = 1'b1;
      end
      default: begin w_exp = '0; w_chk = 1'b0; end
    endcase
    w_mismatch = w_chk && ($unsigned(w_exp) != alu_result);
  end

  logic [CNT_W-1:0] r_err_cnt;
  logic [PC_W-1:0]  r_first_err_pc;
  logic             r_err;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_err_cnt      <= '0;
      r_first_err_pc <= '0;
      r_err          <= 1'b0;
    end else if (retire && w_mismatch) begin
      r_err_cnt <= sat_inc(r_err_cnt);
      r_err     <= 1'b1;
      if (!r_err) r_first_err_pc <= pc;
    end
  end

  assign err_cnt      = r_err_cnt;
  assign first_err_pc = r_first_err_pc;
  assign err          = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{rd1, rd2};
  assign w_mismatch   = 1'b0;
  assign err_cnt      = '0;
  assign first_err_pc = '0;
  assign err          = 1'b0;
`endif

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr;
  logic [AW-1:0]    r_wptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic [CNT_W-1:0] r_retire_cnt;
  logic             r_rd_valid_p1;
  logic [ENT_W-1:0] r_rd_data_p1;

  logic             w_full;
  logic             w_pop;
  logic             w_wr_en;
  logic [ENT_W-1:0] w_entry;

  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = rd_en && (r_count != '0);
  assign w_entry = {pc, instr, alu_result, w_mismatch};
  // A pop frees a slot before the push, so a push only fails when the
  // buffer stays full and overwriting is disabled.
  assign w_wr_en = retire && !rst && !clear && (w_pop || !w_full || (WRAP != 0));

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wptr] <= w_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_retire_cnt  <= '0;
      r_rd_valid_p1 <= 1'b0;
      r_rd_data_p1  <= '0;
    end else if (clear) begin
      r_rptr        <= '0;
      r_wptr        <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_retire_cnt  <= '0;
      r_rd_valid_p1 <= 1'b0;
    end else begin
      // stage p1: popped entry registered onto the read port
      r_rd_valid_p1 <= w_pop;
      if (w_pop) begin
        r_rd_data_p1 <= r_mem[r_rptr];
        r_rptr       <= r_rptr + 1'b1;
      end
      if (retire) begin
        r_retire_cnt <= sat_inc(r_retire_cnt);
        if (w_pop || !w_full) begin
          r_wptr <= r_wptr + 1'b1;
          if (!w_pop) r_count <= r_count + 1'b1;
        end else begin
          r_overflow <= 1'b1;
          // Overwrite mode: the write slot equals the oldest slot, so the
          // read pointer moves past the entry just replaced.
          if (WRAP != 0) begin
            r_wptr <= r_wptr + 1'b1;
            r_rptr <= r_rptr + 1'b1;
          end
        end
      end else if (w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign rd_valid   = r_rd_valid_p1;
  assign rd_data    = r_rd_data_p1;
  assign count      = r_count;
  assign empty      = (r_count == '0);
  assign full       = w_full;
  assign overflow   = r_overflow;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_exec_trace_monitor.sv
module tb_exec_trace_monitor;
  localparam int D    = 4;
  localparam int CW   = 4;
  localparam int ENTW = 64 + 32 + 64 + 1;
`ifdef EXEC_TRACE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [31:0] I_ADD  = 32'h8B00_0000;
  localparam logic [31:0] I_SUB  = 32'hCB00_0000;
  localparam logic [31:0] I_AND  = 32'h8A00_0000;
  localparam logic [31:0] I_ORR  = 32'hAA00_0000;
  localparam logic [31:0] I_LDUR = 32'hF840_0000;
  localparam logic [31:0] I_STUR = 32'hF800_0000;
  localparam logic [31:0] I_CBZ  = 32'hB400_0000;
  localparam logic [31:0] I_B    = 32'h1400_0000;

  typedef logic [ENTW-1:0] ent_t;

  logic clk = 1'b0;
  logic rst, clear, retire, rd_en;
  logic [63:0] pc, rd1, rd2, alu;
  logic [31:0] instr;

  logic        v_a, v_b, e_a, e_b, f_a, f_b, o_a, o_b, er_a, er_b;
  ent_t        d_a, d_b;
  logic [2:0]  c_a, c_b;
  logic [CW-1:0] rc_a, rc_b, ec_a, ec_b;
  logic [63:0] fp_a, fp_b;

  int n_chk = 0;
  int n_fail = 0;

  // model state: ordered list per instance, index 0 = oldest
  ent_t        ml [2][D];
  int          mn [2];
  bit          mov [2];
  bit          mvalid [2];
  ent_t        mdata [2];
  int          mret, merr;
  bit          merrf;
  logic [63:0] mfirst;

  always #5 clk = ~clk;

  exec_trace_monitor #(.DATA_W(64), .PC_W(64), .DEPTH(D), .WRAP(1), .CNT_W(CW)) u_w1 (
    .clk(clk), .rst(rst), .clear(clear), .retire(retire), .pc(pc), .instr(instr),
    .rd1(rd1), .rd2(rd2), .alu_result(alu), .rd_en(rd_en), .rd_valid(v_a), .rd_data(d_a),
    .count(c_a), .empty(e_a), .full(f_a), .overflow(o_a), .retire_cnt(rc_a), .err_cnt(ec_a),
    .first_err_pc(fp_a), .err(er_a));

  exec_trace_monitor #(.DATA_W(64), .PC_W(64), .DEPTH(D), .WRAP(0), .CNT_W(CW)) u_w0 (
    .clk(clk), .rst(rst), .clear(clear), .retire(retire), .pc(pc), .instr(instr),
    .rd1(rd1), .rd2(rd2), .alu_result(alu), .rd_en(rd_en), .rd_valid(v_b), .rd_data(d_b),
    .count(c_b), .empty(e_b), .full(f_b), .overflow(o_b), .retire_cnt(rc_b), .err_cnt(ec_b),
    .first_err_pc(fp_b), .err(er_b));

  // Returns 1 and the expected value when the opcode has a checkable result.
  function automatic bit exp_val(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] e);
    e = 64'd0;
    case (ins[31:21])
      11'b10001011000: begin e = a + b; return 1'b1; end
      11'b11001011000: begin e = a - b; return 1'b1; end
      11'b10001010000: begin e = a & b; return 1'b1; end
      11'b10101010000: begin e = a | b; return 1'b1; end
      11'b11111000010, 11'b11111000000: begin e = a + {55'd0, ins[20:12]}; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit mis_now();
    logic [63:0] e;
    bit c;
    c = exp_val(instr, rd1, rd2, e);
    return CHK && c && (e != alu);
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit m;
    ent_t e;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; mov[k] = 0; mvalid[k] = 0; mdata[k] = '0;
      end
      mret = 0; merr = 0; merrf = 0; mfirst = 64'd0;
    end else if (clear) begin
      for (int k = 0; k < 2; k++) begin
        mn[k] = 0; mov[k] = 0; mvalid[k] = 0;
      end
      mret = 0; merr = 0; merrf = 0; mfirst = 64'd0;
    end else begin
      m = retire && mis_now();
      e = {pc, instr, alu, m};
      for (int k = 0; k < 2; k++) begin
        mvalid[k] = 0;
        if (rd_en && mn[k] > 0) begin
          mdata[k] = ml[k][0];
          for (int i = 0; i < D-1; i++) ml[k][i] = ml[k][i+1];
          mn[k]--;
          mvalid[k] = 1;
        end
        if (retire) begin
          if (mn[k] < D) begin
            ml[k][mn[k]] = e;
            mn[k]++;
          end else begin
            mov[k] = 1;
            if (k == 0) begin
              for (int i = 0; i < D-1; i++) ml[k][i] = ml[k][i+1];
              ml[k][D-1] = e;
            end
          end
        end
      end
      if (retire) begin
        if (mret < 15) mret++;
        if (m) begin
          if (merr < 15) merr++;
          if (!merrf) mfirst = pc;
          merrf = 1;
        end
      end
    end
  endtask

  task automatic cmp_inst(input string p, input int k, input logic v, input ent_t d,
                          input logic [2:0] c, input logic e, input logic f, input logic o,
                          input logic [CW-1:0] rc, input logic [CW-1:0] ec,
                          input logic [63:0] fp, input logic er);
    chk({p, " rd_valid"}, v, mvalid[k]);
    if (mvalid[k]) chk({p, " rd_data"}, d, mdata[k]);
    chk({p, " count"}, c, mn[k]);
    chk({p, " empty"}, e, mn[k] == 0);
    chk({p, " full"}, f, mn[k] == D);
    chk({p, " overflow"}, o, mov[k]);
    chk({p, " retire_cnt"}, rc, mret);
    chk({p, " err_cnt"}, ec, merr);
    chk({p, " first_err_pc"}, fp, mfirst);
    chk({p, " err"}, er, merrf);
  endtask

  // one clock: DUT and model both consume the inputs held across the edge
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    cmp_inst("w1", 0, v_a, d_a, c_a, e_a, f_a, o_a, rc_a, ec_a, fp_a, er_a);
    cmp_inst("w0", 1, v_b, d_b, c_b, e_b, f_b, o_b, rc_b, ec_b, fp_b, er_b);
  endtask

  task automatic drv(input bit r, input bit re, input logic [63:0] p, input logic [31:0] i,
                     input logic [63:0] a, input logic [63:0] b, input logic [63:0] res);
    retire = r; rd_en = re; pc = p; instr = i; rd1 = a; rd2 = b; alu = res;
    cyc();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    clear = 1'b0;
  endtask

  initial begin
    logic [63:0] ev;
    logic [31:0] ops [10];
    logic [31:0] iw;
    bit c;
    rst = 1'b1; clear = 1'b0; retire = 1'b0; rd_en = 1'b0;
    pc = '0; instr = '0; rd1 = '0; rd2 = '0; alu = '0;
    for (int k = 0; k < 2; k++) begin mn[k] = 0; mov[k] = 0; mvalid[k] = 0; mdata[k] = '0; end
    mret = 0; merr = 0; merrf = 0; mfirst = '0;

    // reset state
    cyc(); cyc();
    chk("rst count", c_a, 3'd0);
    chk("rst empty", e_a, 1'b1);
    chk("rst rd_data", d_a, '0);
    rst = 1'b0;

    // ADD 5+7=12 at pc 0, then pop
    drv(1, 0, 64'd0, I_ADD, 64'd5, 64'd7, 64'd12);
    drv(0, 1, 0, 0, 0, 0, 0);
    chk("add retire_cnt", rc_a, 4'd1);
    chk("add err", er_a, 1'b0);
    chk("add rd_valid", v_a, 1'b1);
    chk("add rd_data", d_a, {64'd0, I_ADD, 64'd12, 1'b0});

    // SUB wraps cleanly, ORR with wrong result flags an error
    drv(1, 0, 64'd4, I_SUB, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub err", er_a, 1'b0);
    drv(1, 0, 64'd8, I_ORR, 64'd4, 64'd1, 64'd4);
    chk("orr err", er_a, CHK);
    chk("orr err_cnt", ec_a, CHK ? 4'd1 : 4'd0);
    chk("orr first_err_pc", fp_a, CHK ? 64'd8 : 64'd0);
    drv(0, 1, 0, 0, 0, 0, 0);
    chk("sub entry mismatch", d_a[0], 1'b0);
    drv(0, 1, 0, 0, 0, 0, 0);
    chk("orr entry mismatch", d_a[0], CHK);

    // six retires into a four-deep buffer
    do_clear();
    for (int i = 0; i < 6; i++) drv(1, 0, 64'(4*i), I_ADD, 0, 0, 0);
    chk("ovf full w1", f_a, 1'b1);
    chk("ovf overflow w1", o_a, 1'b1);
    chk("ovf overflow w0", o_b, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 0, 0, 0, 0, 0);
      chk("wrap1 pop pc", d_a[ENTW-1 -: 64], 64'(8 + 4*i));
      chk("wrap0 pop pc", d_b[ENTW-1 -: 64], 64'(4*i));
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    chk("drained empty", e_a, 1'b1);

    // simultaneous retire and pop at full
    do_clear();
    for (int i = 0; i < 4; i++) drv(1, 0, 64'(100 + i), I_AND, 0, 0, 0);
    drv(1, 1, 64'd200, I_AND, 0, 0, 0);
    chk("rw count w1", c_a, 3'd4);
    chk("rw count w0", c_b, 3'd4);
    chk("rw overflow w1", o_a, 1'b0);
    chk("rw overflow w0", o_b, 1'b0);
    for (int i = 0; i < 5; i++) drv(0, 1, 0, 0, 0, 0, 0);
    chk("pop empty rd_valid", v_a, 1'b0);
    // push into empty with rd_en pops nothing
    drv(1, 1, 64'd300, I_CBZ, 0, 0, 0);
    chk("push-empty rd_valid", v_a, 1'b0);
    chk("push-empty count", c_a, 3'd1);

    // reset mid-stream
    do_clear();
    for (int i = 0; i < 3; i++) drv(1, 0, 64'(16 + i), I_ORR, 64'd4, 64'd1, 64'd4);
    chk("pre-rst count", c_a, 3'd3);
    chk("pre-rst err", er_a, CHK);
    rst = 1'b1;
    drv(0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    chk("post-rst count", c_a, 3'd0);
    chk("post-rst empty", e_a, 1'b1);
    chk("post-rst err", er_a, 1'b0);
    chk("post-rst retire_cnt", rc_a, 4'd0);
    chk("post-rst rd_valid", v_a, 1'b0);
    chk("post-rst rd_data", d_a, '0);

    // randomized traffic
    ops = '{I_ADD, I_SUB, I_AND, I_ORR, I_LDUR, I_STUR, I_CBZ, I_B, 32'h0, 32'h0020_0000};
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 99) == 0);
      iw = ops[$urandom_range(0, 9)];
      if (iw != 32'h0) iw = {iw[31:21], 21'($urandom)};
      if ($urandom_range(0, 7) == 0) iw = $urandom;
      retire = $urandom_range(0, 1);
      rd_en  = ($urandom_range(0, 2) == 0);
      pc     = {$urandom, $urandom};
      instr  = iw;
      rd1    = {$urandom, $urandom};
      rd2    = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      c = exp_val(iw, rd1, rd2, ev);
      alu = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : ev;
      cyc();
    end
    rst = 1'b0; clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
